// File: rtl/grant_stream_mux.sv
// Locks one arbiter-granted channel and streams its packet through a
// registered output stage, force-terminating packets at MAX_BEATS beats.

module grant_stream_lane #(
  parameter int DATA_W = 32
) (
  input  logic              lock,
  input  logic              take,
  input  logic              req_valid,
  input  logic [DATA_W-1:0] req_data,
  input  logic              req_last,
  output logic              ready,
  output logic              acc,
  output logic [DATA_W-1:0] data_m,
  output logic              last_m
);
  // Unlocked lanes contribute zeros so the top can OR the lanes together.
  assign ready  = lock & take;
  assign acc    = ready & req_valid;
  assign data_m = lock ? req_data : '0;
  assign last_m = lock & req_last;
endmodule

module grant_stream_mux #(
  parameter int UPTO      = 8,
  parameter int DATA_W    = 32,
  parameter int MAX_BEATS = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [UPTO-1:0]           i_req_valid,
  input  logic [UPTO*DATA_W-1:0]    i_req_data,
  input  logic [UPTO-1:0]           i_req_last,
  output logic [UPTO-1:0]           o_req_ready,
  output logic                      o_arb_ena,
  input  logic [UPTO-1:0]           i_select,
  output logic                      o_valid,
  output logic [DATA_W-1:0]         o_data,
  output logic                      o_last,
  output logic [$clog2(UPTO)-1:0]   o_chan,
  input  logic                      i_ready,
  output logic                      o_err_sel,
  output logic                      o_err_len
);
  localparam int CW = $clog2(UPTO);
  localparam int BW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, XFER} state_t;

  state_t              state_q, state_d;
  logic [UPTO-1:0]     lock_q, lock_d;
  logic [BW-1:0]       cnt_q, cnt_d;
  logic                valid_q, valid_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                last_q, last_d;
  logic [CW-1:0]       chan_q, chan_d;
  logic                err_sel_q, err_sel_d;
  logic                err_len_q, err_len_d;

  logic                       take;
  logic [UPTO-1:0]            acc_v, last_v;
  logic [UPTO-1:0][DATA_W-1:0] data_v;
  logic [DATA_W-1:0]          sel_data;
  logic                       sel_last, accept, forced, eff_last;
  logic [CW-1:0]              lock_idx;
  logic                       sel_onehot, sel_vld;

  assign take = (state_q == XFER) & (~valid_q | i_ready);

  for (genvar k = 0; k < UPTO; k++) begin : g_lane
    grant_stream_lane #(.DATA_W(DATA_W)) u_lane (
      .lock      (lock_q[k]),
      .take      (take),
      .req_valid (i_req_valid[k]),
      .req_data  (i_req_data[k*DATA_W +: DATA_W]),
      .req_last  (i_req_last[k]),
      .ready     (o_req_ready[k]),
      .acc       (acc_v[k]),
      .data_m    (data_v[k]),
      .last_m    (last_v[k])
    );
  end

  // Lock is one-hot while streaming, so OR-combining lanes is a mux.
  always_comb begin
    sel_data = '0;
    lock_idx = '0;
    for (int k = 0; k < UPTO; k++) begin
      sel_data = sel_data | data_v[k];
      lock_idx = lock_idx | (lock_q[k] ? CW'(k) : CW'(0));
    end
  end

  assign sel_last   = |last_v;
  assign accept     = |acc_v;
  assign forced     = (cnt_q == BW'(MAX_BEATS - 1));
  assign eff_last   = sel_last | forced;
  assign sel_onehot = (i_select != '0) && ((i_select & (i_select - UPTO'(1))) == '0);
  assign sel_vld    = |(i_select & i_req_valid);

  always_comb begin
    state_d   = state_q;
    lock_d    = lock_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q & ~i_ready;
    data_d    = data_q;
    last_d    = last_q;
    chan_d    = chan_q;
    err_sel_d = 1'b0;
    err_len_d = 1'b0;
    o_arb_ena = 1'b0;
    case (state_q)
      IDLE: begin
        if (|i_req_valid) begin
          o_arb_ena = 1'b1;
          state_d   = GRANT;
        end
      end
      GRANT: begin
        if (sel_onehot && sel_vld) begin
          lock_d  = i_select;
          cnt_d   = '0;
          state_d = XFER;
        end else begin
          lock_d    = '0;
          err_sel_d = 1'b1;
          state_d   = IDLE;
        end
      end
      XFER: begin
        if (accept) begin
          valid_d   = 1'b1;
          data_d    = sel_data;
          last_d    = eff_last;
          chan_d    = lock_idx;
          err_len_d = forced & ~sel_last;
          cnt_d     = cnt_q + BW'(1);
          if (eff_last) begin
            lock_d  = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      lock_q    <= '0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      last_q    <= 1'b0;
      chan_q    <= '0;
      err_sel_q <= 1'b0;
      err_len_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lock_q    <= lock_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      last_q    <= last_d;
      chan_q    <= chan_d;
      err_sel_q <= err_sel_d;
      err_len_q <= err_len_d;
    end
  end

  assign o_valid   = valid_q;
  assign o_data    = data_q;
  assign o_last    = last_q;
  assign o_chan    = chan_q;
  assign o_err_sel = err_sel_q;
  assign o_err_len = err_len_q;

endmodule

// File: tb/tb_grant_stream_mux.sv
// Randomized and directed bench for grant_stream_mux against a queue-based
// reference model, with a round-robin arbiter model closing the grant loop.
module tb_grant_stream_mux;
  localparam int UPTO = 8, DW = 32, MB = 4, CW = 3;
  localparam int WAIT_REQ = 0, AWAIT_GNT = 1, STREAM = 2;

  logic              clk = 1'b0, rst_n = 1'b0;
  logic [UPTO-1:0]   req_valid = '0, req_last = '0, req_ready, select = '0;
  logic [UPTO*DW-1:0] req_data = '0;
  logic              arb_ena, o_valid, o_last, rdy_in = 1'b0, err_sel, err_len;
  logic [DW-1:0]     o_data;
  logic [CW-1:0]     o_chan;

  always #5 clk = ~clk;

  grant_stream_mux #(.UPTO(UPTO), .DATA_W(DW), .MAX_BEATS(MB)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .i_req_data(req_data),
    .i_req_last(req_last), .o_req_ready(req_ready), .o_arb_ena(arb_ena),
    .i_select(select), .o_valid(o_valid), .o_data(o_data), .o_last(o_last),
    .o_chan(o_chan), .i_ready(rdy_in), .o_err_sel(err_sel), .o_err_len(err_len)
  );

  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // source queues of {last, data}
  logic [DW:0] chq [UPTO][$];
  int en_pct = 100, rdy_pct = 100, lo_from = -1, lo_to = -1, cyc = 0;
  int rr_last = UPTO - 1;
  bit force_bad = 0;
  logic [UPTO-1:0] sel_next = '0;

  // reference model: phase, locked channel, beats taken, output register
  int ph = WAIT_REQ, lk = 0, nb = 0, oc = 0;
  bit ov = 0, ol = 0, es = 0, el = 0;
  logic [DW-1:0] od = '0;

  int dlv_chan[$]; logic [DW-1:0] dlv_data[$]; bit dlv_last[$];
  int n_es = 0, n_el = 0, first_rdy = -1, first_ov = -1;

  task automatic start_test();
    dlv_chan.delete(); dlv_data.delete(); dlv_last.delete();
    cyc = 0; first_rdy = -1; first_ov = -1; lo_from = -1; lo_to = -1;
  endtask

  task automatic step();
    logic [UPTO-1:0] v, l, sel_drv, exp_rdy;
    logic [UPTO*DW-1:0] d;
    logic [DW:0] b;
    logic rdy;
    bit arb_x, acc, forced, efl, es_n, el_n;
    int c;
    @(negedge clk);
    for (int k = 0; k < UPTO; k++) begin
      v[k] = (($urandom_range(99) < en_pct) && chq[k].size() > 0);
      if (v[k]) b = chq[k][0];
      else begin b = '0; b[DW-1:0] = $urandom; b[DW] = 1'($urandom_range(1)); end
      l[k] = b[DW];
      d[k*DW +: DW] = b[DW-1:0];
    end
    rdy = (cyc >= lo_from && cyc <= lo_to) ? 1'b0 : ($urandom_range(99) < rdy_pct);
    sel_drv = sel_next;
    req_valid = v; req_last = l; req_data = d; rdy_in = rdy; select = sel_drv;
    #1;
    arb_x = (ph == WAIT_REQ) && (|v);
    chk("arb_ena", arb_ena, arb_x);
    exp_rdy = '0;
    if (ph == STREAM && (!ov || rdy)) exp_rdy[lk] = 1'b1;
    chk("req_ready", req_ready, exp_rdy);
    chk("o_valid", o_valid, ov);
    if (ov) begin
      chk("o_data", o_data, od);
      chk("o_chan", o_chan, oc);
      chk("o_last", o_last, ol);
    end
    chk("err_sel", err_sel, es);
    chk("err_len", err_len, el);
    if (req_ready != '0 && first_rdy < 0) first_rdy = cyc;
    if (o_valid && first_ov < 0) first_ov = cyc;
    if (o_valid && rdy) begin
      dlv_chan.push_back(int'(o_chan)); dlv_data.push_back(o_data); dlv_last.push_back(o_last);
    end
    n_es += int'(err_sel);
    n_el += int'(err_len);
    // arbiter model: real grant only after an arb request, junk otherwise
    if (arb_ena) begin
      sel_next = '0;
      if (force_bad) force_bad = 0;
      else
        for (int i = 1; i <= UPTO; i++) begin
          c = (rr_last + i) % UPTO;
          if (v[c] && sel_next == '0) begin sel_next[c] = 1'b1; rr_last = c; end
        end
    end else sel_next = UPTO'($urandom);
    // model advances across the coming edge
    es_n = 0; el_n = 0;
    case (ph)
      WAIT_REQ: begin
        if (|v) ph = AWAIT_GNT;
        if (rdy) ov = 0;
      end
      AWAIT_GNT: begin
        c = -1;
        for (int k = 0; k < UPTO; k++) if (sel_drv[k]) c = k;
        if ($countones(sel_drv) == 1 && v[c]) begin ph = STREAM; lk = c; nb = 0; end
        else begin es_n = 1; ph = WAIT_REQ; end
        if (rdy) ov = 0;
      end
      default: begin
        acc = v[lk] && (!ov || rdy);
        if (acc) begin
          b = chq[lk].pop_front();
          nb++;
          forced = (nb == MB);
          efl = b[DW] || forced;
          ov = 1; od = b[DW-1:0]; ol = efl; oc = lk;
          el_n = forced && !b[DW];
          if (efl) ph = WAIT_REQ;
        end else if (rdy) ov = 0;
      end
    endcase
    es = es_n; el = el_n;
    cyc++;
  endtask

  function automatic bit all_idle();
    for (int k = 0; k < UPTO; k++) if (chq[k].size() != 0) return 0;
    return (ph == WAIT_REQ) && !ov;
  endfunction

  task automatic run_until_idle(input string tag, input int maxc);
    bit busy;
    for (int i = 0; i < maxc && !all_idle(); i++) step();
    busy = !all_idle();
    chk(tag, busy, 0);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_ready", req_ready, 0);
    for (int k = 0; k < UPTO; k++) chq[k].delete();
    req_valid = '0;
    ph = WAIT_REQ; ov = 0; es = 0; el = 0; nb = 0;
    @(negedge clk);
    chk("rst_data", o_data, 0);
    chk("rst_chan", o_chan, 0);
    chk("rst_last", o_last, 0);
    chk("rst_errs", {err_sel, err_len}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic push_pkt(input int ch, input int len, input logic [DW-1:0] base, input bit with_last);
    for (int i = 0; i < len; i++)
      chq[ch].push_back({with_last && (i == len - 1), base + DW'(i)});
  endtask

  initial begin
    int tot, nlong, len, ch, el0, es0;
    logic [UPTO-1:0] seen;
    logic [DW-1:0] abc [3];
    abc[0] = 32'hA; abc[1] = 32'hB; abc[2] = 32'hC;

    repeat (3) @(negedge clk);
    #1;
    chk("init_valid", o_valid, 0);
    chk("init_ready", req_ready, 0);
    chk("init_data", o_data, 0);
    chk("init_chan", o_chan, 0);
    chk("init_errs", {err_sel, err_len, o_last}, 3'b000);
    rst_n = 1'b1;

    // single packet on ch2, then the same packet under backpressure
    for (int t = 0; t < 2; t++) begin
      start_test();
      if (t == 1) begin lo_from = 3; lo_to = 6; end
      push_pkt(2, 3, 32'hA, 1);
      run_until_idle("pkt_drain", 60);
      chk("lat_ready", first_rdy, 2);
      chk("lat_valid", first_ov, 3);
      chk("pkt_beats", dlv_data.size(), 3);
      for (int i = 0; i < dlv_data.size() && i < 3; i++) begin
        chk("pkt_data", dlv_data[i], abc[i]);
        chk("pkt_chan", dlv_chan[i], 2);
        chk("pkt_last", dlv_last[i], i == 2);
      end
    end

    // bad grant with every channel requesting
    start_test();
    es0 = n_es; force_bad = 1;
    for (int k = 0; k < UPTO; k++) push_pkt(k, 1, 32'h100 + DW'(k), 1);
    run_until_idle("bad_drain", 300);
    chk("bad_err_sel_cnt", n_es - es0, 1);
    seen = '0;
    foreach (dlv_chan[i]) seen[dlv_chan[i]] = 1'b1;
    chk("bad_all_served", seen, {UPTO{1'b1}});

    // round robin between ch0 and ch3
    start_test();
    rr_last = UPTO - 1;
    for (int i = 0; i < 4; i++) begin
      push_pkt(0, 1, 32'h200 + DW'(i), 1);
      push_pkt(3, 1, 32'h300 + DW'(i), 1);
    end
    run_until_idle("rr_drain", 200);
    chk("rr_beats", dlv_chan.size(), 8);
    for (int i = 0; i < dlv_chan.size(); i++) chk("rr_chan", dlv_chan[i], (i % 2) ? 3 : 0);

    // randomized traffic with valid gaps and downstream stalls
    start_test();
    en_pct = 85; rdy_pct = 70; tot = 0; nlong = 0; el0 = n_el;
    for (int p = 0; p < 40; p++) begin
      ch = $urandom_range(UPTO - 1);
      len = $urandom_range(1, 6);
      tot += len;
      if (len > MB) nlong++;
      push_pkt(ch, len, $urandom, 1);
    end
    run_until_idle("rand_drain", 20000);
    chk("rand_beats", dlv_data.size(), tot);
    chk("rand_err_len", n_el - el0, nlong);
    en_pct = 100; rdy_pct = 100;

    // forced last: 6 beats with no last, the tail stalls until reset
    start_test();
    el0 = n_el;
    push_pkt(5, 6, 32'h50, 0);
    repeat (25) step();
    chk("fl_beats", dlv_data.size(), 6);
    for (int i = 0; i < dlv_last.size(); i++) chk("fl_last", dlv_last[i], i == 3);
    chk("fl_err_len", n_el - el0, 1);
    do_reset();

    // reset while beat 2 of 4 is on the output, then a fresh packet
    start_test();
    push_pkt(1, 4, 32'h10, 1);
    for (int i = 0; i < 50 && !(ov && nb == 2); i++) step();
    chk("mid_reached", ov && nb == 2, 1);
    do_reset();
    start_test();
    el0 = n_el;
    push_pkt(1, 4, 32'h20, 1);
    run_until_idle("post_rst_drain", 60);
    chk("post_rst_lat", first_ov, 3);
    chk("post_rst_beats", dlv_data.size(), 4);
    for (int i = 0; i < dlv_data.size(); i++) begin
      chk("post_rst_data", dlv_data[i], 32'h20 + DW'(i));
      chk("post_rst_last", dlv_last[i], i == 3);
    end
    chk("post_rst_err_len", n_el - el0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/grant_stream_mux.md
GRANT_STREAM_MUX -- requirements
Module: grant_stream_mux

Interface
REQ-001 Parameter UPTO, default 8, meaning: number of requesting channels (2..128).
REQ-002 Parameter DATA_W, default 32, meaning: payload width per beat.
REQ-003 Parameter MAX_BEATS, default 16, meaning: maximum beats per packet before forced termination (1..65535).
REQ-004 i_clk  input  1  system clock; the block uses this single clock only.
REQ-005 i_rst_n  input  1  asynchronous, active-low reset.
REQ-006 i_req_valid  input  UPTO  per-channel beat valid; also routed externally to the arbiter request bitmap.
REQ-007 i_req_data  input  UPTO*DATA_W  per-channel payload; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-008 i_req_last  input  UPTO  per-channel end-of-packet flag.
REQ-009 o_req_ready  output  UPTO  per-channel beat accept.
REQ-010 o_arb_ena  output  1  grant-update strobe to the upstream round-robin arbiter.
REQ-011 i_select  input  UPTO  one-hot grant from the arbiter; it is valid on the cycle after o_arb_ena.
REQ-012 o_valid / o_data / o_last  output  1 / DATA_W / 1  registered output stream.
REQ-013 o_chan  output  $clog2(UPTO)  binary index of the channel owning the current o_data.
REQ-014 i_ready  input  1  downstream accept.
REQ-015 o_err_sel  output  1  one-cycle pulse when the captured grant is invalid.
REQ-016 o_err_len  output  1  one-cycle pulse when a packet is force-terminated at MAX_BEATS.

Function
REQ-017 The FSM SHALL have three states: IDLE, GRANT and XFER.
REQ-018 In IDLE, o_arb_ena SHALL be combinationally high when |i_req_valid is true, and the FSM SHALL move to GRANT on the same edge.
REQ-019 o_arb_ena SHALL be low in GRANT and XFER.
REQ-020 In GRANT, i_select SHALL be captured into the one-hot lock register, and the binary lock index SHALL be computed by an OR-reduction encoder.
REQ-021 If the captured value is exactly one-hot and i_req_valid of that channel is high, the FSM SHALL move from GRANT to XFER.
REQ-022 Otherwise (zero, multi-hot, or granted channel not valid), the block SHALL pulse o_err_sel, clear the lock and return to IDLE.
REQ-023 In XFER, o_req_ready[k] SHALL equal lock[k] & (!o_valid | i_ready); all other ready bits SHALL be 0.
REQ-024 A beat SHALL be accepted when i_req_valid[k] & o_req_ready[k]; the output register then loads the data, last (or the forced last) and the lock index, and sets o_valid.
REQ-025 o_valid SHALL clear on i_ready when no new beat is loaded in the same cycle; the output SHALL hold stable while o_valid & !i_ready.
REQ-026 A beat counter SHALL reset to 0 on entry to XFER and increment per accepted beat.
REQ-027 The beat on which the count reaches MAX_BEATS-1 SHALL be emitted with o_last=1; if i_req_last was 0 on that beat, o_err_len SHALL pulse.
REQ-028 After a beat with effective last is accepted, the FSM SHALL go to IDLE.
REQ-029 The FSM SHALL NOT be able to re-request arbitration before the next cycle, giving a minimum of 2 idle input cycles between packets.
REQ-030 A drop of the locked channel's valid mid-packet SHALL stall XFER with no timeout.
REQ-031 Valid toggling on non-locked channels SHALL be ignored during XFER.
REQ-032 A change of i_select outside GRANT SHALL be ignored.
REQ-033 Latency SHALL be as follows: a request in IDLE at cycle 0 gives first ready at cycle 2 and o_valid at cycle 3.

Reset
REQ-034 Asserting i_rst_n low at any time SHALL asynchronously force: FSM=IDLE, lock=0, beat counter=0, o_valid=0, o_last=0, o_chan=0, o_data=0, o_err_sel=0, o_err_len=0.
REQ-035 A packet in flight at reset SHALL be discarded with no further beats emitted.
REQ-036 While in reset, o_req_ready=0; o_arb_ena may follow the IDLE rule once reset is released.

Verification
REQ-037 Single packet: ch2 sends 3 beats (0xA,0xB,0xC, last on 0xC), arbiter grants 0000_0100, i_ready=1 -> o_arb_ena high at cycle 0; beats appear cycles 3-5 with o_chan=2; o_last on 0xC.
REQ-038 Backpressure: same as REQ-037 with i_ready low for cycles 3-6 -> o_data holds 0xA, o_req_ready[2]=0 while stalled, no beat lost or duplicated.
REQ-039 Bad grant: all channels valid, arbiter returns 0000_0000 in GRANT -> o_err_sel pulses 1 cycle, FSM in IDLE next cycle, o_arb_ena reasserted.
REQ-040 Forced last: MAX_BEATS=4, ch5 streams 6 beats with no last -> 4th beat carries o_last=1, o_err_len pulses once, FSM returns to IDLE.
REQ-041 Round robin: ch0 and ch3 continuously valid with 1-beat packets, bench arbiter model connected -> o_chan alternates 0,3,0,3.
REQ-042 Reset mid-packet: i_rst_n low during beat 2 of 4 -> o_valid=0 immediately (asynchronous); after release, the next packet starts from GRANT with beat count 0.
